// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, payload width
// and the default bit period (100 MHz clock, 115200 baud).
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk  - destination clock
//   rst  - synchronous active-high reset, loads RESET_VAL into both flops
//   d    - asynchronous input
//   q    - synchronized output
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two back-to-back flops to let metastability settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, mid-bit sampling, with a one-deep valid/ready output.
// Ports:
//   CLK        - clock, rising edge
//   RST        - synchronous active-high reset
//   uart_rx_in - asynchronous serial line, idle high
//   rx_data    - received byte, stable while rx_valid is high
//   rx_valid   - byte available, held until accepted
//   rx_ready   - consumer accepts when rx_valid && rx_ready on a rising edge
//   frame_err  - one-cycle pulse when a stop bit is sampled low
//   overrun    - one-cycle pulse when a completed byte is dropped
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEFAULT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 uart_rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_r;
    uart_state_e          state_next_s;
    logic [CNT_W-1:0]     cyc_cnt_r;
    logic [CNT_W-1:0]     cyc_next_s;
    logic [2:0]           bit_cnt_r;
    logic [2:0]           bit_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [DATA_BITS-1:0] shift_next_s;
    logic                 done_s;
    logic                 ferr_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (CLK),
        .rst (RST),
        .d   (uart_rx_in),
        .q   (rx_s)
    );

    // Receiver state, counters and shift register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= IDLE;
            cyc_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r <= 3'd0;
            shift_r   <= {DATA_BITS{1'b0}};
        end else begin
            state_r   <= state_next_s;
            cyc_cnt_r <= cyc_next_s;
            bit_cnt_r <= bit_next_s;
            shift_r   <= shift_next_s;
        end
    end

    // Next-state logic: timing from the falling start edge, mid-bit sampling
    always_comb begin
        state_next_s = state_r;
        cyc_next_s   = cyc_cnt_r;
        bit_next_s   = bit_cnt_r;
        shift_next_s = shift_r;
        done_s       = 1'b0;
        ferr_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (rx_s == 1'b0) begin
                    state_next_s = START;
                    cyc_next_s   = {CNT_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (cyc_cnt_r == HALF_LAST) begin
                    // A line already high again at mid start bit is a glitch
                    if (rx_s == 1'b1) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DATA;
                        cyc_next_s   = {CNT_W{1'b0}};
                        bit_next_s   = 3'd0;
                    end
                end else begin
                    cyc_next_s = cyc_cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cyc_cnt_r == BIT_LAST) begin
                    cyc_next_s   = {CNT_W{1'b0}};
                    shift_next_s = {rx_s, shift_r[DATA_BITS-1:1]};
                    if (bit_cnt_r == LAST_BIT) begin
                        state_next_s = STOP;
                    end else begin
                        bit_next_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    cyc_next_s = cyc_cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cyc_cnt_r == BIT_LAST) begin
                    cyc_next_s = {CNT_W{1'b0}};
                    if (rx_s == 1'b1) begin
                        done_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        ferr_s       = 1'b1;
                        state_next_s = WAIT_HIGH;
                    end
                end else begin
                    cyc_next_s = cyc_cnt_r + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // Hold off during a break so it cannot retrigger start bits
                if (rx_s == 1'b1) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_HIGH;
                end
            end
            default: begin
                state_next_s = IDLE;
                cyc_next_s   = {CNT_W{1'b0}};
                bit_next_s   = 3'd0;
            end
        endcase
    end

    // Output holding register with valid/ready handshake and error pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_data   <= {DATA_BITS{1'b0}};
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_s;
            overrun   <= 1'b0;
            if (done_s) begin
                // Slot is free, or is being emptied on this very edge
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift_r;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end else begin
                rx_valid <= rx_valid;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       CLK        = 1'b0;
    logic       RST        = 1'b1;
    logic       uart_rx_in = 1'b1;
    logic       rx_ready   = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    always #5 CLK = ~CLK;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .uart_rx_in (uart_rx_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observed events, collected on the falling edge
    logic [7:0] got_q[$];
    int         ferr_cnt    = 0;
    int         ovr_cnt     = 0;
    int         valid_cycles = 0;
    int         stab_err    = 0;
    logic       prev_hold   = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    // Reference model: a one-entry holding slot fed by completed frames
    logic [7:0] exp_q[$];
    int         exp_ferr   = 0;
    int         exp_ovr    = 0;
    logic       mdl_valid  = 1'b0;
    logic [7:0] mdl_data   = 8'h00;

    // Monitor: accepted bytes, error pulses and rx_data stability
    always @(negedge CLK) begin
        if (!RST) begin
            if (frame_err) ferr_cnt <= ferr_cnt + 1;
            if (overrun) ovr_cnt <= ovr_cnt + 1;
            if (rx_valid) valid_cycles <= valid_cycles + 1;
            if (prev_hold && (rx_data !== prev_data)) stab_err <= stab_err + 1;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
            prev_hold <= rx_valid && !rx_ready;
            prev_data <= rx_data;
        end else begin
            prev_hold <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        uart_rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_in = b[i];
            tick(CPB);
        end
        uart_rx_in = stop;
        tick(CPB);
    endtask

    // A good frame finishes; accept_now means the held byte leaves on that edge
    task automatic mdl_complete(input logic [7:0] b, input logic accept_now);
        if (mdl_valid && accept_now) begin
            exp_q.push_back(mdl_data);
            mdl_data = b;
        end else if (mdl_valid) begin
            exp_ovr++;
        end else begin
            mdl_valid = 1'b1;
            mdl_data  = b;
        end
    endtask

    task automatic mdl_accept();
        if (mdl_valid) exp_q.push_back(mdl_data);
        mdl_valid = 1'b0;
    endtask

    int vc0;
    int fe0;
    int ov0;

    initial begin
        // Reset state
        RST = 1'b1;
        tick(4);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_overrun", 32'(overrun), 32'h0);
        check("reset_state", 32'(dut.state_r), 32'(IDLE));
        RST = 1'b0;
        tick(4);

        // 0x55, rx_ready high: exact latency and a single valid cycle
        rx_ready = 1'b1;
        vc0 = valid_cycles;
        fork
            send_frame(8'h55, 1'b1);
            begin
                // start edge + 2 sync + 1 IDLE decision + CPB/2 + 9*CPB
                repeat (3 + CPB / 2 + 9 * CPB - 1) @(posedge CLK);
                #1;
                check("lat_before", 32'(rx_valid), 32'h0);
                @(posedge CLK);
                #1;
                check("lat_valid", 32'(rx_valid), 32'h1);
                check("lat_data", 32'(rx_data), 32'h55);
            end
        join
        tick(CPB);
        mdl_complete(8'h55, 1'b0);
        mdl_accept();
        check("x55_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
        check("x55_no_err", 32'(ferr_cnt + ovr_cnt), 32'd0);

        // 0xA3 then 0x0F back-to-back with rx_ready low
        rx_ready = 1'b0;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        tick(CPB);
        mdl_complete(8'hA3, 1'b0);
        mdl_complete(8'h0F, 1'b0);
        check("ovr_hold_valid", 32'(rx_valid), 32'h1);
        check("ovr_hold_data", 32'(rx_data), 32'hA3);
        check("ovr_count", 32'(ovr_cnt), 32'(exp_ovr));
        rx_ready = 1'b1;
        tick(1);
        mdl_accept();
        check("ovr_drain_valid", 32'(rx_valid), 32'h0);

        // 4-cycle low glitch
        vc0 = valid_cycles;
        fe0 = ferr_cnt;
        ov0 = ovr_cnt;
        uart_rx_in = 1'b0;
        tick(4);
        uart_rx_in = 1'b1;
        tick(1);
        check("glitch_in_start", 32'(dut.state_r), 32'(START));
        tick(2 * CPB);
        check("glitch_back_idle", 32'(dut.state_r), 32'(IDLE));
        check("glitch_no_events", 32'((valid_cycles - vc0) + (ferr_cnt - fe0) + (ovr_cnt - ov0)), 32'd0);

        // Completion on the same edge the held byte is accepted
        rx_ready = 1'b0;
        send_frame(8'h96, 1'b1);
        mdl_complete(8'h96, 1'b0);
        ov0 = ovr_cnt;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                repeat (3 + CPB / 2 + 9 * CPB - 1) @(posedge CLK);
                #1;
                rx_ready = 1'b1;
                @(posedge CLK);
                #1;
                rx_ready = 1'b0;
                check("same_valid", 32'(rx_valid), 32'h1);
                check("same_data", 32'(rx_data), 32'h5A);
                check("same_overrun", 32'(overrun), 32'h0);
            end
        join
        mdl_complete(8'h5A, 1'b1);
        tick(CPB);
        check("same_no_ovr", 32'(ovr_cnt - ov0), 32'd0);
        rx_ready = 1'b1;
        tick(1);
        mdl_accept();
        check("same_drain_valid", 32'(rx_valid), 32'h0);

        // 0xFF with low stop bit, then a 40-bit break
        fe0 = ferr_cnt;
        vc0 = valid_cycles;
        send_frame(8'hFF, 1'b0);
        exp_ferr++;
        tick(40 * CPB);
        check("break_wait_high", 32'(dut.state_r), 32'(WAIT_HIGH));
        check("break_one_ferr", 32'(ferr_cnt - fe0), 32'd1);
        check("break_no_byte", 32'(valid_cycles - vc0), 32'd0);
        uart_rx_in = 1'b1;
        tick(2 * CPB);
        check("break_idle", 32'(dut.state_r), 32'(IDLE));
        send_frame(8'h3C, 1'b1);
        tick(CPB);
        mdl_complete(8'h3C, 1'b0);
        mdl_accept();
        check("after_break_data", 32'(rx_data), 32'h3C);

        // Reset during bit 4 of a frame
        vc0 = valid_cycles;
        uart_rx_in = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            uart_rx_in = (i == 3) ? 1'b0 : 1'b1;
            tick(CPB);
        end
        uart_rx_in = 1'b1;
        tick(CPB / 2);
        RST = 1'b1;
        tick(3);
        check("rst_mid_state", 32'(dut.state_r), 32'(IDLE));
        check("rst_mid_data", 32'(rx_data), 32'h00);
        check("rst_mid_outs", 32'({rx_valid, frame_err, overrun}), 32'h0);
        RST = 1'b0;
        tick(5 * CPB);
        check("rst_no_partial", 32'(valid_cycles - vc0), 32'd0);
        send_frame(8'h81, 1'b1);
        tick(CPB);
        mdl_complete(8'h81, 1'b0);
        mdl_accept();
        check("after_rst_data", 32'(rx_data), 32'h81);

        // Random frames, occasional bad stop bit, random idle gaps
        rx_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            uart_rx_in = 1'b1;
            tick($urandom_range(4, 20));
            if (stop) begin
                mdl_complete(b, 1'b0);
                mdl_accept();
            end else begin
                exp_ferr++;
            end
        end
        tick(CPB);

        // Scoreboard comparison
        check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("byte_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        check("ferr_total", 32'(ferr_cnt), 32'(exp_ferr));
        check("ovr_total", 32'(ovr_cnt), 32'(exp_ovr));
        check("data_stable", 32'(stab_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
